// File: rtl/vreg_file.sv
// Vector register file: NUM_VREGS x MAX_VL elements, two element-serial read
// streams and one masked write stream, with readers chained behind the writer.
module vreg_file #(
  parameter int NUM_VREGS = 8,
  parameter int MAX_VL    = 16,
  parameter int ELEM_W    = 32,
  parameter int RESET_VL  = 8,
  parameter int IDX_W     = $clog2(NUM_VREGS),
  parameter int EIDX_W    = $clog2(MAX_VL),
  parameter int VL_W      = $clog2(MAX_VL + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vl_wr_en,
  input  logic [31:0]       vl_wr_data,
  output logic [VL_W-1:0]   vl,
  input  logic              rda_start,
  input  logic [IDX_W-1:0]  rda_vs,
  output logic              rda_busy,
  output logic              rda_valid,
  input  logic              rda_ready,
  output logic [ELEM_W-1:0] rda_data,
  output logic [EIDX_W-1:0] rda_idx,
  output logic              rda_last,
  input  logic              rdb_start,
  input  logic [IDX_W-1:0]  rdb_vs,
  output logic              rdb_busy,
  output logic              rdb_valid,
  input  logic              rdb_ready,
  output logic [ELEM_W-1:0] rdb_data,
  output logic [EIDX_W-1:0] rdb_idx,
  output logic              rdb_last,
  input  logic              wr_start,
  input  logic [IDX_W-1:0]  wr_vd,
  output logic              wr_busy,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic              wr_mask,
  output logic              wr_done
);
  localparam int NUM_RD = 2;

  typedef enum logic {S_IDLE, S_ACTIVE} st_e;

  logic [ELEM_W-1:0] mem [NUM_VREGS][MAX_VL];
  logic [VL_W-1:0]   vl_q;

  assign vl = vl_q;

  always_ff @(posedge clk) begin
    if (reset)
      vl_q <= VL_W'(RESET_VL);
    else if (vl_wr_en)
      vl_q <= (vl_wr_data > 32'(MAX_VL)) ? VL_W'(MAX_VL) : vl_wr_data[VL_W-1:0];
  end

  // ---------------- write stream ----------------
  st_e               wr_st;
  logic [EIDX_W-1:0] wr_cnt;
  logic [VL_W-1:0]   wr_snap;
  logic [IDX_W-1:0]  wr_vd_q;
  logic              wr_done_q;
  logic              wr_beat, wr_final;

  assign wr_busy  = (wr_st == S_ACTIVE);
  assign wr_ready = wr_busy;
  assign wr_done  = wr_done_q;
  assign wr_beat  = wr_busy && wr_valid;
  assign wr_final = wr_beat && ((VL_W'(wr_cnt) + VL_W'(1)) == wr_snap);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_st     <= S_IDLE;
      wr_cnt    <= '0;
      wr_snap   <= '0;
      wr_vd_q   <= '0;
      wr_done_q <= 1'b0;
    end else begin
      // zero-length write completes immediately but still signals done
      wr_done_q <= wr_final || (wr_start && !wr_busy && (vl_q == '0));
      case (wr_st)
        S_IDLE: if (wr_start && (vl_q != '0)) begin
          wr_st   <= S_ACTIVE;
          wr_cnt  <= '0;
          wr_snap <= vl_q;
          wr_vd_q <= wr_vd;
        end
        S_ACTIVE: if (wr_beat) begin
          if (wr_final) begin
            wr_st  <= S_IDLE;
            wr_cnt <= '0;
          end else begin
            wr_cnt <= wr_cnt + EIDX_W'(1);
          end
        end
        default: wr_st <= S_IDLE;
      endcase
    end
  end

  // Array is not reset; a beat coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_beat && wr_mask)
      mem[wr_vd_q][wr_cnt] <= wr_data;
  end

  // ---------------- read streams ----------------
  logic [NUM_RD-1:0]             rd_start, rd_ready, rd_busy, rd_valid, rd_last;
  logic [NUM_RD-1:0][IDX_W-1:0]  rd_vs;
  logic [NUM_RD-1:0][EIDX_W-1:0] rd_idx;
  logic [NUM_RD-1:0][ELEM_W-1:0] rd_data;

  assign rd_start = {rdb_start, rda_start};
  assign rd_ready = {rdb_ready, rda_ready};
  assign rd_vs    = {rdb_vs, rda_vs};

  assign rda_busy  = rd_busy[0];
  assign rda_valid = rd_valid[0];
  assign rda_data  = rd_data[0];
  assign rda_idx   = rd_idx[0];
  assign rda_last  = rd_last[0];
  assign rdb_busy  = rd_busy[1];
  assign rdb_valid = rd_valid[1];
  assign rdb_data  = rd_data[1];
  assign rdb_idx   = rd_idx[1];
  assign rdb_last  = rd_last[1];

  generate
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      st_e               st;
      logic [EIDX_W-1:0] cnt;
      logic [VL_W-1:0]   snap;
      logic [IDX_W-1:0]  src;
      logic              stall;

      // Hold off on any element the in-flight writer has not yet passed.
      assign stall       = wr_busy && (wr_vd_q == src) && (cnt >= wr_cnt);
      assign rd_busy[g]  = (st == S_ACTIVE);
      assign rd_valid[g] = rd_busy[g] && !stall;
      assign rd_last[g]  = rd_busy[g] && ((VL_W'(cnt) + VL_W'(1)) == snap);
      assign rd_idx[g]   = cnt;
      assign rd_data[g]  = mem[src][cnt];

      always_ff @(posedge clk) begin
        if (reset) begin
          st   <= S_IDLE;
          cnt  <= '0;
          snap <= '0;
          src  <= '0;
        end else begin
          case (st)
            S_IDLE: if (rd_start[g] && (vl_q != '0)) begin
              st   <= S_ACTIVE;
              cnt  <= '0;
              snap <= vl_q;
              src  <= rd_vs[g];
            end
            S_ACTIVE: if (rd_valid[g] && rd_ready[g]) begin
              if (rd_last[g]) begin
                st  <= S_IDLE;
                cnt <= '0;
              end else begin
                cnt <= cnt + EIDX_W'(1);
              end
            end
            default: st <= S_IDLE;
          endcase
        end
      end
    end
  endgenerate

endmodule
